// File: rtl/microcode_control_pkg.sv
// Shared ISA/control definitions for the multi-cycle microcode controller.
// Holds the FSM state encoding, datapath mux encodings, RV32 major opcode
// constants (instruction bits [6:2]) and mcause trap codes.
package microcode_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_MEM      = 3'd2,
        ST_MEM_DONE = 3'd3,
        ST_TRAP     = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    // Memory address source
    localparam logic [1:0] ADDR_PC  = 2'd0;
    localparam logic [1:0] ADDR_ALU = 2'd1;

    // Register-file write-back source
    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] RD_CSR = 2'd2;

    // ALU operand 1: register, PC or zero
    localparam logic [1:0] IN1_RS = 2'd0;
    localparam logic [1:0] IN1_PC = 2'd1;
    localparam logic [1:0] IN1_ZR = 2'd2;

    // ALU operand 2: register, immediate or instruction size (link value)
    localparam logic [1:0] IN2_RS = 2'd0;
    localparam logic [1:0] IN2_IM = 2'd1;
    localparam logic [1:0] IN2_IS = 2'd2;

    // Major opcodes, instruction bits [6:2]
    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_MISCMEM = 5'b00011;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_OP      = 5'b01100;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

    // mcause codes
    localparam logic [3:0] CAUSE_NONE        = 4'd0;
    localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M     = 4'd11;

endpackage

// File: rtl/microcode_control_mem_watchdog.sv
// mem_watchdog: counts wait cycles of one memory access.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : hold count at zero (outside an access)
//   tick       : one more cycle spent waiting
//   expired    : this wait cycle is the TIMEOUT-th one; always 0 when TIMEOUT=0
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    // Width is $clog2(TIMEOUT+1); keep one bit when the watchdog is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (tick && cnt != LIMIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires in the cycle whose increment makes the count reach TIMEOUT, so the
    // controller leaves after exactly TIMEOUT unanswered cycles.
    assign expired = (TIMEOUT != 0) && tick && !clear && (cnt == LIMIT_M1);

endmodule

// File: rtl/microcode_control.sv
// microcode_control: multi-cycle RV32 control FSM (fetch, decode, memory,
// trap, debug halt) driving datapath strobes and mux selects.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   opcode[4:0], f3[2:0]       : IR bits [6:2] and funct3 (IR stable after fetch)
//   mem_complete               : memory access finished this cycle
//   halt_req, resume_req       : debug requests
//   write_pc..load_op          : datapath strobes
//   addr_sel, rd_sel,
//   alu_insel1, alu_insel2     : datapath mux selects (package encodings)
//   trap, trap_cause, retire   : trap pulse, held mcause, retire pulse
//   halted                     : core is in debug halt
//   dbg_state                  : current FSM state
//
// Handshake: a memory access is requested by holding mem_read/mem_write with a
// stable address; it is accepted in the cycle mem_complete=1, at which point
// the FSM advances. The controller never withdraws a request except on
// timeout or reset.
module microcode_control
    import microcode_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit HAS_DEBUG   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic [2:0] f3,
    input  logic       mem_complete,
    input  logic       halt_req,
    input  logic       resume_req,
    output logic       write_pc,
    output logic       write_rd,
    output logic       write_csr,
    output logic       write_ir,
    output logic       mem_read,
    output logic       mem_write,
    output logic       load_op,
    output logic [1:0] addr_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2,
    output logic       trap,
    output logic [3:0] trap_cause,
    output logic       retire,
    output logic       halted,
    output logic [2:0] dbg_state
);
    state_t     state, state_nxt;
    logic [3:0] cause_q, cause_nxt;
    logic       wd_clear, wd_tick, wd_expired;
    logic       in_access;
    logic       is_store;
    state_t     fetch_target;

    mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
        end
    end

    // Counter runs only while waiting on memory; any other state clears it,
    // so it is zero on every entry into FETCH or MEM.
    assign in_access = (state == ST_FETCH) || (state == ST_MEM);
    assign wd_clear  = !in_access;
    assign wd_tick   = in_access && !mem_complete;

    assign is_store   = (opcode == OPC_STORE);
    assign trap_cause = cause_q;
    assign dbg_state  = state;

    // halt_req is only looked at when the FSM is about to enter FETCH.
    assign fetch_target = (HAS_DEBUG && halt_req) ? ST_HALT : ST_FETCH;

    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause_q;
        write_pc   = 1'b0;
        write_rd   = 1'b0;
        write_csr  = 1'b0;
        write_ir   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        load_op    = 1'b0;
        addr_sel   = ADDR_PC;
        rd_sel     = RD_ALU;
        alu_insel1 = IN1_RS;
        alu_insel2 = IN2_RS;
        trap       = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_read = 1'b1;
                write_ir = 1'b1;
                if (mem_complete) begin
                    state_nxt = ST_DECODE;
                end else if (wd_expired) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_FETCH_FAULT;
                end
            end

            ST_DECODE: begin
                case (opcode)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OP: begin
                        case (opcode)
                            OPC_LUI:   begin alu_insel1 = IN1_ZR; alu_insel2 = IN2_IM; end
                            OPC_AUIPC: begin alu_insel1 = IN1_PC; alu_insel2 = IN2_IM; end
                            OPC_JAL,
                            OPC_JALR:  begin alu_insel1 = IN1_PC; alu_insel2 = IN2_IS; end
                            OPC_OPIMM: begin alu_insel1 = IN1_RS; alu_insel2 = IN2_IM; end
                            default:   begin alu_insel1 = IN1_RS; alu_insel2 = IN2_RS; end
                        endcase
                        write_rd  = 1'b1;
                        rd_sel    = RD_ALU;
                        write_pc  = 1'b1;
                        retire    = 1'b1;
                        state_nxt = fetch_target;
                    end
                    OPC_BRANCH, OPC_MISCMEM: begin
                        write_pc  = 1'b1;
                        retire    = 1'b1;
                        state_nxt = fetch_target;
                    end
                    OPC_SYSTEM: begin
                        if (f3 != 3'd0) begin
                            rd_sel    = RD_CSR;
                            write_rd  = 1'b1;
                            write_csr = 1'b1;
                            write_pc  = 1'b1;
                            retire    = 1'b1;
                            state_nxt = fetch_target;
                        end else begin
                            state_nxt = ST_TRAP;
                            cause_nxt = CAUSE_ECALL_M;
                        end
                    end
                    OPC_LOAD, OPC_STORE: begin
                        state_nxt = ST_MEM;
                    end
                    default: begin
                        state_nxt = ST_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                alu_insel1 = IN1_RS;
                alu_insel2 = IN2_IM;
                addr_sel   = ADDR_ALU;
                mem_read   = !is_store;
                mem_write  = is_store;
                if (mem_complete) begin
                    state_nxt = ST_MEM_DONE;
                end else if (wd_expired) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                end
            end

            ST_MEM_DONE: begin
                if (!is_store) begin
                    write_rd = 1'b1;
                    rd_sel   = RD_MEM;
                    load_op  = 1'b1;
                end
                write_pc  = 1'b1;
                retire    = 1'b1;
                state_nxt = fetch_target;
            end

            ST_TRAP: begin
                trap      = 1'b1;
                write_pc  = 1'b1;
                state_nxt = fetch_target;
            end

            ST_HALT: begin
                halted = HAS_DEBUG;
                if (!HAS_DEBUG || (resume_req && !halt_req)) begin
                    state_nxt = ST_FETCH;
                end
            end

            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_microcode_control.sv
module tb_microcode_control;
    import microcode_control_pkg::*;

    // Strobe vector bit positions:
    // {write_pc, write_rd, write_csr, write_ir, mem_read, mem_write, load_op, trap, retire, halted}
    localparam logic [9:0] B_WPC  = 10'b10_0000_0000;
    localparam logic [9:0] B_WRD  = 10'b01_0000_0000;
    localparam logic [9:0] B_WCSR = 10'b00_1000_0000;
    localparam logic [9:0] B_WIR  = 10'b00_0100_0000;
    localparam logic [9:0] B_MRD  = 10'b00_0010_0000;
    localparam logic [9:0] B_MWR  = 10'b00_0001_0000;
    localparam logic [9:0] B_LOAD = 10'b00_0000_1000;
    localparam logic [9:0] B_TRAP = 10'b00_0000_0100;
    localparam logic [9:0] B_RET  = 10'b00_0000_0010;
    localparam logic [9:0] B_HALT = 10'b00_0000_0001;
    localparam logic [9:0] FETCH_STRB = B_WIR | B_MRD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] opcode;
    logic [2:0] f3;
    logic       mem_complete, halt_req, resume_req;
    logic       write_pc, write_rd, write_csr, write_ir, mem_read, mem_write, load_op;
    logic [1:0] addr_sel, rd_sel, alu_insel1, alu_insel2;
    logic       trap, retire, halted;
    logic [3:0] trap_cause;
    logic [2:0] dbg_state;
    logic [9:0] strb;

    int checks = 0;
    int errors = 0;

    assign strb = {write_pc, write_rd, write_csr, write_ir, mem_read, mem_write,
                   load_op, trap, retire, halted};

    microcode_control #(.MEM_TIMEOUT(4), .HAS_DEBUG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .f3(f3),
        .mem_complete(mem_complete), .halt_req(halt_req), .resume_req(resume_req),
        .write_pc(write_pc), .write_rd(write_rd), .write_csr(write_csr),
        .write_ir(write_ir), .mem_read(mem_read), .mem_write(mem_write),
        .load_op(load_op), .addr_sel(addr_sel), .rd_sel(rd_sel),
        .alu_insel1(alu_insel1), .alu_insel2(alu_insel2), .trap(trap),
        .trap_cause(trap_cause), .retire(retire), .halted(halted),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Driver: complete a fetch of (op, fn3); leaves the FSM in DECODE.
    task automatic do_fetch(input logic [4:0] op, input logic [2:0] fn3);
        opcode = op;
        f3 = fn3;
        mem_complete = 1'b1;
        #1;
        cyc();
        mem_complete = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = OPC_OP; f3 = 3'd0;
        mem_complete = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
        cyc(); cyc();
        #1;
        checks++;
        if (strb !== FETCH_STRB || addr_sel !== ADDR_PC) begin
            errors++;
            $display("FAIL reset_strobes strb=%b addr=%0d exp strb=%b addr=%0d", strb, addr_sel, FETCH_STRB, ADDR_PC);
        end
        checks++;
        if (dbg_state !== 3'(ST_FETCH) || trap_cause !== 4'd0) begin
            errors++;
            $display("FAIL reset_state state=%0d cause=%0d exp state=0 cause=0", dbg_state, trap_cause);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    // ALU-class instructions: 2 cycles each, mux selects per opcode.
    task automatic test_alu_ops();
        logic [4:0] ops [6] = '{OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
        logic [1:0] e1  [6] = '{IN1_RS, IN1_RS, IN1_ZR, IN1_PC, IN1_PC, IN1_PC};
        logic [1:0] e2  [6] = '{IN2_RS, IN2_IM, IN2_IM, IN2_IM, IN2_IS, IN2_IS};
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            mem_complete = 1'b1;
            #1;
            checks++;
            if (dbg_state !== 3'(ST_FETCH) || strb !== FETCH_STRB) begin
                errors++;
                $display("FAIL alu_fetch[%0d] state=%0d strb=%b exp state=0 strb=%b", i, dbg_state, strb, FETCH_STRB);
            end
            cyc();
            mem_complete = 1'b0;
            #1;
            checks++;
            if (dbg_state !== 3'(ST_DECODE) || strb !== (B_WPC | B_WRD | B_RET)
                || {alu_insel1, alu_insel2, rd_sel} !== {e1[i], e2[i], RD_ALU}) begin
                errors++;
                $display("FAIL alu_decode[%0d] state=%0d strb=%b sel=%b exp state=1 strb=%b sel=%b",
                         i, dbg_state, strb, {alu_insel1, alu_insel2, rd_sel}, B_WPC | B_WRD | B_RET,
                         {e1[i], e2[i], RD_ALU});
            end
            cyc();
        end
        #1;
        checks++;
        if (dbg_state !== 3'(ST_FETCH)) begin
            errors++;
            $display("FAIL alu_back_to_fetch state=%0d exp 0", dbg_state);
        end
    endtask

    task automatic test_branch_csr();
        do_fetch(OPC_BRANCH, 3'd0);
        #1;
        checks++;
        if (strb !== (B_WPC | B_RET)) begin
            errors++;
            $display("FAIL branch_decode strb=%b exp %b", strb, B_WPC | B_RET);
        end
        cyc();
        do_fetch(OPC_SYSTEM, 3'd1);
        #1;
        checks++;
        if (strb !== (B_WPC | B_WRD | B_WCSR | B_RET) || rd_sel !== RD_CSR) begin
            errors++;
            $display("FAIL csr_decode strb=%b rd_sel=%0d exp strb=%b rd_sel=%0d",
                     strb, rd_sel, B_WPC | B_WRD | B_WCSR | B_RET, RD_CSR);
        end
        cyc();
    endtask

    // Load answered on the 4th MEM cycle: the cycle where the watchdog would
    // otherwise expire, so completion must win.
    task automatic test_load();
        int rd_cycles = 0;
        do_fetch(OPC_LOAD, 3'd2);
        #1;
        checks++;
        if (dbg_state !== 3'(ST_DECODE) || strb !== 10'd0) begin
            errors++;
            $display("FAIL load_decode state=%0d strb=%b exp state=1 strb=0", dbg_state, strb);
        end
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_complete = (i == 3);
            #1;
            if (dbg_state == 3'(ST_MEM) && strb == B_MRD && addr_sel == ADDR_ALU
                && alu_insel1 == IN1_RS && alu_insel2 == IN2_IM) rd_cycles++;
            cyc();
        end
        mem_complete = 1'b0;
        checks++;
        if (rd_cycles !== 4) begin
            errors++;
            $display("FAIL load_mem_cycles got=%0d exp=4", rd_cycles);
        end
        #1;
        checks++;
        if (dbg_state !== 3'(ST_MEM_DONE) || strb !== (B_WRD | B_LOAD | B_WPC | B_RET) || rd_sel !== RD_MEM) begin
            errors++;
            $display("FAIL load_done state=%0d strb=%b rd_sel=%0d exp state=3 strb=%b rd_sel=%0d",
                     dbg_state, strb, rd_sel, B_WRD | B_LOAD | B_WPC | B_RET, RD_MEM);
        end
        cyc();
    endtask

    task automatic test_store_timeout();
        int wr_cycles = 0;
        do_fetch(OPC_STORE, 3'd2);
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            if (dbg_state == 3'(ST_MEM) && strb == B_MWR && addr_sel == ADDR_ALU) wr_cycles++;
            cyc();
        end
        checks++;
        if (wr_cycles !== 4) begin
            errors++;
            $display("FAIL store_wait_cycles got=%0d exp=4", wr_cycles);
        end
        #1;
        checks++;
        if (dbg_state !== 3'(ST_TRAP) || strb !== (B_TRAP | B_WPC) || trap_cause !== 4'd7) begin
            errors++;
            $display("FAIL store_trap state=%0d strb=%b cause=%0d exp state=4 strb=%b cause=7",
                     dbg_state, strb, trap_cause, B_TRAP | B_WPC);
        end
        cyc();
        #1;
        checks++;
        if (dbg_state !== 3'(ST_FETCH) || trap_cause !== 4'd7 || strb !== FETCH_STRB) begin
            errors++;
            $display("FAIL store_after_trap state=%0d cause=%0d strb=%b exp state=0 cause=7 strb=%b",
                     dbg_state, trap_cause, strb, FETCH_STRB);
        end
    endtask

    task automatic test_illegal();
        do_fetch(5'b11111, 3'd0);
        #1;
        checks++;
        if (strb !== 10'd0) begin
            errors++;
            $display("FAIL illegal_decode strb=%b exp 0", strb);
        end
        cyc();
        #1;
        checks++;
        if (dbg_state !== 3'(ST_TRAP) || trap_cause !== 4'd2 || strb !== (B_TRAP | B_WPC)) begin
            errors++;
            $display("FAIL illegal_trap state=%0d cause=%0d strb=%b exp state=4 cause=2 strb=%b",
                     dbg_state, trap_cause, strb, B_TRAP | B_WPC);
        end
        cyc();
        do_fetch(OPC_SYSTEM, 3'd0);
        cyc();
        #1;
        checks++;
        if (dbg_state !== 3'(ST_TRAP) || trap_cause !== 4'd11) begin
            errors++;
            $display("FAIL ecall_trap state=%0d cause=%0d exp state=4 cause=11", dbg_state, trap_cause);
        end
        cyc();
    endtask

    task automatic test_halt();
        do_fetch(OPC_LOAD, 3'd0);
        cyc();
        halt_req = 1'b1;
        cyc();
        mem_complete = 1'b1;
        #1;
        cyc();
        mem_complete = 1'b0;
        #1;
        checks++;
        if (dbg_state !== 3'(ST_MEM_DONE) || retire !== 1'b1) begin
            errors++;
            $display("FAIL halt_retire state=%0d retire=%b exp state=3 retire=1", dbg_state, retire);
        end
        cyc();
        #1;
        checks++;
        if (dbg_state !== 3'(ST_HALT) || strb !== B_HALT) begin
            errors++;
            $display("FAIL halt_enter state=%0d strb=%b exp state=5 strb=%b", dbg_state, strb, B_HALT);
        end
        resume_req = 1'b1;
        cyc();
        #1;
        checks++;
        if (dbg_state !== 3'(ST_HALT)) begin
            errors++;
            $display("FAIL halt_both_high state=%0d exp 5", dbg_state);
        end
        halt_req = 1'b0;
        cyc();
        resume_req = 1'b0;
        #1;
        checks++;
        if (dbg_state !== 3'(ST_FETCH) || strb !== FETCH_STRB) begin
            errors++;
            $display("FAIL halt_resume state=%0d strb=%b exp state=0 strb=%b", dbg_state, strb, FETCH_STRB);
        end
    endtask

    // Reset during a store wait, then a fetch timeout that must take exactly
    // four cycles, showing the counter restarted from zero.
    task automatic test_reset_mid();
        int fetch_cycles = 0;
        do_fetch(OPC_STORE, 3'd0);
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        #1;
        checks++;
        if (dbg_state !== 3'(ST_FETCH) || mem_write !== 1'b0 || trap_cause !== 4'd0 || strb !== FETCH_STRB) begin
            errors++;
            $display("FAIL reset_mid state=%0d mem_write=%b cause=%0d strb=%b exp state=0 mem_write=0 cause=0 strb=%b",
                     dbg_state, mem_write, trap_cause, strb, FETCH_STRB);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (dbg_state == 3'(ST_FETCH)) fetch_cycles++;
            cyc();
        end
        #1;
        checks++;
        if (fetch_cycles !== 4 || dbg_state !== 3'(ST_TRAP) || trap_cause !== 4'd1) begin
            errors++;
            $display("FAIL fetch_timeout cycles=%0d state=%0d cause=%0d exp cycles=4 state=4 cause=1",
                     fetch_cycles, dbg_state, trap_cause);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch_csr();
        test_load();
        test_store_timeout();
        test_illegal();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
